// File: rtl/exec_sequencer_if.sv
// Handshake and control bundle between exec_sequencer and the lab datapath,
// instruction memory and data memory.
interface exec_sequencer_if;
    logic        start;
    logic [15:0] instr_data;
    logic [3:0]  ALUFlags;
    logic        mem_ack;
    logic [7:0]  instr_addr;
    logic        WE;
    logic        ALUorM;
    logic [2:0]  ALUCntr;
    logic        ALUSrc2;
    logic [1:0]  RDst3;
    logic [1:0]  RSrc1;
    logic [7:0]  Src2;
    logic        mem_req;
    logic        busy;
    logic        halted;
    logic [2:0]  state;

    modport master (
        input  start, instr_data, ALUFlags, mem_ack,
        output instr_addr, WE, ALUorM, ALUCntr, ALUSrc2, RDst3, RSrc1, Src2,
        output mem_req, busy, halted, state
    );

    modport slave (
        output start, instr_data, ALUFlags, mem_ack,
        input  instr_addr, WE, ALUorM, ALUCntr, ALUSrc2, RDst3, RSrc1, Src2,
        input  mem_req, busy, halted, state
    );
endinterface

// File: rtl/exec_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback sequencer: owns the PC, decodes IR
// into datapath controls, resolves branches from registered flags, handshakes loads.
module exec_sequencer (
    input logic              clk,
    input logic              reset,
    exec_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StFetch   = 3'd1,
        StDecode  = 3'd2,
        StExec    = 3'd3,
        StMemWait = 3'd4,
        StWb      = 3'd5,
        StHalt    = 3'd6
    } state_e;

    state_e      state_q;
    logic [7:0]  pc_q;
    logic [15:0] ir_q;
    logic [3:0]  flags_q;
    logic        we_q;
    logic        mem_req_q;
    logic        busy_q;
    logic        halted_q;

    logic [2:0]  opcode;
    logic        is_halt;
    logic        is_alu;
    logic        is_load;
    logic        br_taken;
    logic [7:0]  pc_inc;

    always_comb begin
        opcode   = ir_q[15:13];
        // The all-ones word would otherwise decode as a branch.
        is_halt  = (ir_q == 16'hFFFF);
        is_alu   = !is_halt && (opcode <= 3'd5);
        is_load  = !is_halt && (opcode == 3'd6);
        br_taken = flags_q[ir_q[10:9]] ^ ir_q[8];
        pc_inc   = pc_q + 8'd1;
    end

    assign bus.instr_addr = pc_q;
    assign bus.WE         = we_q;
    assign bus.ALUorM     = is_load;
    assign bus.ALUCntr    = is_alu ? opcode : 3'd0;
    assign bus.ALUSrc2    = ir_q[8];
    assign bus.RDst3      = ir_q[12:11];
    assign bus.RSrc1      = ir_q[10:9];
    assign bus.Src2       = ir_q[7:0];
    assign bus.mem_req    = mem_req_q;
    assign bus.busy       = busy_q;
    assign bus.halted     = halted_q;
    assign bus.state      = state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            pc_q      <= 8'd0;
            ir_q      <= 16'd0;
            flags_q   <= 4'd0;
            we_q      <= 1'b0;
            mem_req_q <= 1'b0;
            busy_q    <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            we_q      <= 1'b0;
            mem_req_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        state_q <= StFetch;
                        busy_q  <= 1'b1;
                    end
                end
                StFetch: begin
                    ir_q    <= bus.instr_data;
                    state_q <= StDecode;
                end
                StDecode: begin
                    if (is_halt) begin
                        state_q  <= StHalt;
                        busy_q   <= 1'b0;
                        halted_q <= 1'b1;
                    end else begin
                        state_q <= StExec;
                    end
                end
                StExec: begin
                    if (is_alu) begin
                        flags_q <= bus.ALUFlags;
                        pc_q    <= pc_inc;
                        we_q    <= 1'b1;
                        state_q <= StWb;
                    end else if (is_load) begin
                        pc_q      <= pc_inc;
                        mem_req_q <= 1'b1;
                        state_q   <= StMemWait;
                    end else begin
                        pc_q    <= br_taken ? ir_q[7:0] : pc_inc;
                        state_q <= StFetch;
                    end
                end
                StMemWait: begin
                    if (bus.mem_ack) begin
                        we_q    <= 1'b1;
                        state_q <= StWb;
                    end else begin
                        mem_req_q <= 1'b1;
                    end
                end
                StWb: begin
                    state_q <= StFetch;
                end
                StHalt: begin
                    if (bus.start) begin
                        pc_q     <= 8'd0;
                        flags_q  <= 4'd0;
                        busy_q   <= 1'b1;
                        halted_q <= 1'b0;
                        state_q  <= StFetch;
                    end
                end
                default: begin
                    busy_q   <= 1'b0;
                    halted_q <= 1'b0;
                    state_q  <= StIdle;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_exec_sequencer.sv
// Scoreboard bench for exec_sequencer: an instruction-level model predicts fetches,
// writebacks and halts; a monitor pops and compares as the DUT presents them.
module tb_exec_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    exec_sequencer_if bus();

    exec_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [15:0] imem     [256];
    logic [3:0]  flag_tab [256];
    int          dly_tab  [256];

    assign bus.instr_data = imem[bus.instr_addr];
    assign bus.ALUFlags   = flag_tab[bus.instr_addr];

    typedef struct { int pc; int cyc; } ev_t;
    typedef struct { int rd; int aluorm; int cntr; int cyc; } wb_t;

    ev_t fetch_q[$];
    ev_t halt_q[$];
    wb_t wb_q[$];

    int errors = 0;
    int checks = 0;
    int cyc_now = 0;
    int base = 0;
    int ack_mode = 0;  // 0: timed ack from dly_tab, 1: forced low, 2: forced high
    int ack_cnt = 0;
    bit mon_en = 0;
    bit prev_halted = 0;
    int rel;
    ev_t mf;
    wb_t mw;

    localparam int Limit = 120;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string msg);
        checks++;
        errors++;
        $display("FAIL %s", msg);
    endtask

    always @(posedge clk) cyc_now <= cyc_now + 1;

    // Load delay is keyed by the LOAD's own address; PC has already advanced in MEMWAIT.
    always @(posedge clk) begin
        logic [7:0] ld_pc;
        #1;
        ld_pc = bus.instr_addr - 8'd1;
        if (bus.mem_req) ack_cnt++;
        else ack_cnt = 0;
        if (ack_mode == 1) bus.mem_ack = 1'b0;
        else if (ack_mode == 2) bus.mem_ack = 1'b1;
        else if (bus.mem_req) bus.mem_ack = (ack_cnt >= dly_tab[ld_pc]);
        else bus.mem_ack = 1'($urandom);
    end

    always @(negedge clk) begin
        if (mon_en) begin
            rel = cyc_now - base;
            check("busy", int'(bus.busy), int'(bus.state inside {[3'd1:3'd5]}));
            check("mem_req", int'(bus.mem_req), int'(bus.state == 3'd4));
            check("we_state", int'(bus.WE), int'(bus.state == 3'd5));
            check("halted", int'(bus.halted), int'(bus.state == 3'd6));
            if (bus.state == 3'd1) begin
                if (fetch_q.size() == 0) begin
                    fail_now($sformatf("fetch_extra: got fetch at 0x%0h, required none",
                                       bus.instr_addr));
                end else begin
                    mf = fetch_q.pop_front();
                    check("fetch_addr", int'(bus.instr_addr), mf.pc);
                    check("fetch_cycle", rel, mf.cyc);
                end
            end
            if (bus.WE) begin
                if (wb_q.size() == 0) begin
                    fail_now($sformatf("we_extra: got WE at cycle %0d, required none", rel));
                end else begin
                    mw = wb_q.pop_front();
                    check("wb_rdst", int'(bus.RDst3), mw.rd);
                    check("wb_aluorm", int'(bus.ALUorM), mw.aluorm);
                    check("wb_alucntr", int'(bus.ALUCntr), mw.cntr);
                    check("wb_cycle", rel, mw.cyc);
                end
            end
            if (bus.halted && !prev_halted) begin
                if (halt_q.size() == 0) begin
                    fail_now($sformatf("halt_extra: got halt at 0x%0h, required none",
                                       bus.instr_addr));
                end else begin
                    mf = halt_q.pop_front();
                    check("halt_addr", int'(bus.instr_addr), mf.pc);
                    check("halt_cycle", rel, mf.cyc);
                end
            end
        end
        prev_halted = bus.halted;
    end

    // Instruction-level reference: latencies ALU 4, BRANCH 3, LOAD 4+n, HALT after decode.
    task automatic run_model(input bit push, output bit halted_o, output logic [7:0] stop_pc);
        logic [7:0]  pc;
        logic [3:0]  fl;
        logic [15:0] w;
        int          cyc;
        pc = 8'd0;
        fl = 4'd0;
        cyc = 1;
        halted_o = 1'b0;
        for (int n = 0; ; n++) begin
            w = imem[pc];
            if (w != 16'hFFFF && n >= Limit) break;
            if (push) fetch_q.push_back('{pc: int'(pc), cyc: cyc});
            if (w == 16'hFFFF) begin
                if (push) halt_q.push_back('{pc: int'(pc), cyc: cyc + 2});
                halted_o = 1'b1;
                break;
            end
            if (w[15:13] == 3'd7) begin
                if (fl[w[10:9]] ^ w[8]) pc = w[7:0];
                else pc = pc + 8'd1;
                cyc += 3;
            end else if (w[15:13] == 3'd6) begin
                if (push) wb_q.push_back('{rd: int'(w[12:11]), aluorm: 1, cntr: 0,
                                           cyc: cyc + 3 + dly_tab[pc]});
                cyc += 4 + dly_tab[pc];
                pc = pc + 8'd1;
            end else begin
                if (push) wb_q.push_back('{rd: int'(w[12:11]), aluorm: 0,
                                           cntr: int'(w[15:13]), cyc: cyc + 3});
                fl = flag_tab[pc];
                pc = pc + 8'd1;
                cyc += 4;
            end
        end
        stop_pc = pc;
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1;
        base = cyc_now;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_drain(input int budget, input bit poke);
        int n;
        n = 0;
        while ((fetch_q.size() != 0 || wb_q.size() != 0 || halt_q.size() != 0)
               && n < budget) begin
            @(posedge clk);
            #1;
            // A start pulse during EXEC must be ignored.
            bus.start = poke && (bus.state == 3'd3);
            n++;
        end
        bus.start = 1'b0;
        if (n >= budget) begin
            fail_now($sformatf("drain_timeout: got %0d events pending, required 0",
                               fetch_q.size() + wb_q.size() + halt_q.size()));
            fetch_q.delete();
            wb_q.delete();
            halt_q.delete();
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic run_program(input bit poke);
        bit         h;
        logic [7:0] sp;
        run_model(1'b0, h, sp);
        if (!h) imem[sp] = 16'hFFFF;
        run_model(1'b1, h, sp);
        pulse_start();
        wait_drain(4000, poke);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) begin
            imem[i] = 16'hFFFF;
            flag_tab[i] = 4'd0;
            dly_tab[i] = 1;
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        bus.start = 1'b0;
        clear_mem();

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", int'(bus.state), 0);
        check("rst_pc", int'(bus.instr_addr), 0);
        check("rst_we", int'(bus.WE), 0);
        check("rst_mem_req", int'(bus.mem_req), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_halted", int'(bus.halted), 0);
        check("rst_alucntr", int'(bus.ALUCntr), 0);
        check("rst_aluorm", int'(bus.ALUorM), 0);
        check("rst_rdst", int'(bus.RDst3), 0);
        check("rst_rsrc", int'(bus.RSrc1), 0);
        check("rst_alusrc2", int'(bus.ALUSrc2), 0);
        check("rst_src2", int'(bus.Src2), 0);
        reset = 1'b0;
        mon_en = 1'b1;

        // add, sub, halt; start poked during each EXEC
        imem[0] = 16'h0803;
        imem[1] = 16'h2A01;
        imem[2] = 16'hFFFF;
        run_program(1'b1);
        check("p1_halt_pc", int'(bus.instr_addr), 2);

        // SUB sets Z, taken branch to 0x20, untaken branch there, delayed LOAD
        clear_mem();
        imem[8'h00] = 16'h2000;
        flag_tab[8'h00] = 4'b0100;
        imem[8'h01] = 16'hE420;
        imem[8'h20] = 16'hE540;
        imem[8'h21] = 16'hD005;
        dly_tab[8'h21] = 3;
        run_program(1'b0);

        // Restart from HALT must clear FLAGS: Z-taken branch now falls through
        imem[8'h00] = 16'hE430;
        imem[8'h01] = 16'hFFFF;
        run_program(1'b0);
        check("restart_halt_pc", int'(bus.instr_addr), 1);

        // PC wrap: taken FE->FF, untaken at FF -> 00
        clear_mem();
        imem[8'h00] = 16'hE210;
        imem[8'h01] = 16'h1807;
        flag_tab[8'h01] = 4'b0010;
        imem[8'h02] = 16'hE1FE;
        imem[8'hFE] = 16'hE1FF;
        imem[8'hFF] = 16'hE055;
        run_program(1'b0);

        // Reset during MEMWAIT with ack held low
        clear_mem();
        imem[8'h00] = 16'hC800;
        ack_mode = 1;
        fetch_q.push_back('{pc: 0, cyc: 1});
        pulse_start();
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(posedge clk);
            #1;
            ok = (bus.state == 3'd4);
        end
        check("reached_memwait", int'(ok), 1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("mw_rst_state", int'(bus.state), 0);
        check("mw_rst_mem_req", int'(bus.mem_req), 0);
        check("mw_rst_we", int'(bus.WE), 0);
        check("mw_rst_pc", int'(bus.instr_addr), 0);
        check("mw_rst_fetch_seen", fetch_q.size(), 0);
        ack_mode = 2;
        repeat (5) begin
            @(posedge clk);
            #1;
            check("idle_ignores_ack", int'(bus.state), 0);
        end
        ack_mode = 0;

        // Randomized programs
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 256; i++) begin
                logic [15:0] w;
                w = 16'($urandom);
                if ($urandom_range(0, 49) == 0) w = 16'hFFFF;
                imem[i] = w;
                flag_tab[i] = 4'($urandom);
                dly_tab[i] = $urandom_range(1, 4);
            end
            run_program(r[0]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
